// File: rtl/demux_pkg.sv
// Shared constants and FSM state type for the demux round-robin collector.
package demux_pkg;

    localparam int N_CH  = 8;
    localparam int IDX_W = 3;

    // IDLE: nothing offered; OFFER: out_idx held on out_valid until accepted
    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request bit found when
// scanning from ptr upward, wrapping from N_CH-1 back to 0.
module rr_pick #(
    parameter int N_CH  = demux_pkg::N_CH,
    parameter int IDX_W = demux_pkg::IDX_W
) (
    input  logic [N_CH-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // cand_idx[k] is the channel visited k steps after ptr
    logic [IDX_W-1:0] cand_idx [N_CH];
    logic [N_CH-1:0]  cand_req;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_cand
            logic [IDX_W:0] sum;
            assign sum = {1'b0, ptr} + (IDX_W + 1)'(gi);
            assign cand_idx[gi] = (sum >= (IDX_W + 1)'(N_CH)) ?
                                  IDX_W'(sum - (IDX_W + 1)'(N_CH)) :
                                  IDX_W'(sum);
            assign cand_req[gi] = req[cand_idx[gi]];
        end
    endgenerate

    // Scan from the farthest offset down so the nearest request to ptr wins
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (cand_req[k]) begin
                idx = cand_idx[k];
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/demux_rr_collector.sv
// Collects per-channel event pulses from a demux into a pending register and
// offers one pending channel index at a time, chosen round-robin, over a
// valid/ready handshake. Re-arrival of an unserved event raises a sticky
// per-channel overflow flag.
module demux_rr_collector #(
    parameter int N_CH  = demux_pkg::N_CH,
    parameter int IDX_W = demux_pkg::IDX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_CH-1:0]  din,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic [N_CH-1:0]  pending,
    output logic [N_CH-1:0]  ovf,
    input  logic             ovf_clr
);

    import demux_pkg::*;

    state_t           state_reg;
    state_t           state_next;
    logic [N_CH-1:0]  pending_reg;
    logic [N_CH-1:0]  pending_next;
    logic [N_CH-1:0]  ovf_reg;
    logic [N_CH-1:0]  ovf_next;
    logic [IDX_W-1:0] ptr_reg;
    logic [IDX_W-1:0] ptr_next;
    logic [IDX_W-1:0] out_idx_reg;
    logic [IDX_W-1:0] out_idx_next;
    logic [N_CH-1:0]  clr_mask;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic             handshake;

    rr_pick #(
        .N_CH  (N_CH),
        .IDX_W (IDX_W)
    ) u_pick (
        .req (pending_reg),
        .ptr (ptr_reg),
        .idx (pick_idx),
        .any (pick_any)
    );

    // out_ready only matters while an index is actually on offer
    assign handshake = (state_reg == OFFER) && out_ready;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_clr
            assign clr_mask[gi] = handshake && (out_idx_reg == IDX_W'(gi));
        end
    endgenerate

    // Pending/overflow update: a new event beats the handshake clear of the
    // same bit, and a bit being cleared this cycle cannot overflow
    always_comb begin
        pending_next = (pending_reg & ~clr_mask) | din;
        ovf_next     = (ovf_clr ? '0 : ovf_reg) | (din & pending_reg & ~clr_mask);
    end

    // FSM next-state: latch the winner on entry to OFFER, advance ptr past
    // the accepted index on handshake
    always_comb begin
        state_next   = state_reg;
        out_idx_next = out_idx_reg;
        ptr_next     = ptr_reg;
        case (state_reg)
            IDLE: begin
                if (pick_any) begin
                    state_next   = OFFER;
                    out_idx_next = pick_idx;
                end
            end
            OFFER: begin
                if (out_ready) begin
                    state_next = IDLE;
                    ptr_next   = (out_idx_reg == IDX_W'(N_CH - 1)) ?
                                 '0 : out_idx_reg + IDX_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Datapath registers; reset discards any offer in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_reg <= '0;
            ovf_reg     <= '0;
            ptr_reg     <= '0;
            out_idx_reg <= '0;
        end else begin
            pending_reg <= pending_next;
            ovf_reg     <= ovf_next;
            ptr_reg     <= ptr_next;
            out_idx_reg <= out_idx_next;
        end
    end

    assign out_valid = (state_reg == OFFER);
    assign out_idx   = out_idx_reg;
    assign pending   = pending_reg;
    assign ovf       = ovf_reg;

endmodule

// File: tb/tb_demux_rr_collector.sv
// Self-checking bench for demux_rr_collector: expected grant indices are
// queued as stimulus is applied and popped by a handshake monitor.
module tb_demux_rr_collector;

    logic       clk;
    logic       rst_n;
    logic [7:0] din;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_idx;
    logic [7:0] pending;
    logic [7:0] ovf;
    logic       ovf_clr;

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;
    int last_grant_cyc = 0;
    int prev_grant_cyc = 0;
    int exp_q[$];

    demux_rr_collector #(
        .N_CH  (8),
        .IDX_W (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .pending   (pending),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Handshake monitor: inputs change just after posedge, so at negedge the
    // values that the next posedge will act on are stable
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            int e;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL grant_unexpected: got idx %0d, required no grant", out_idx);
            end else begin
                e = exp_q.pop_front();
                if (out_idx !== 3'(e)) begin
                    n_fail++;
                    $display("FAIL grant_idx: got %0d, required %0d", out_idx, e);
                end else begin
                    $display("grant idx %0d at cycle %0d", out_idx, cycle);
                end
            end
            prev_grant_cyc = last_grant_cyc;
            last_grant_cyc = cycle;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d grants outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!out_valid && n < budget) begin
            tick();
            n++;
        end
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL valid_timeout: got out_valid %b, required 1", out_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; din = 8'hFF; out_ready = 1'b1; ovf_clr = 1'b1;
        repeat (3) tick();
        n_checks++;
        if ({pending, ovf, out_valid, out_idx} !== {8'h00, 8'h00, 1'b0, 3'd0}) begin
            n_fail++;
            $display("FAIL reset_state: got pending %h ovf %h valid %b idx %0d, required 00 00 0 0",
                     pending, ovf, out_valid, out_idx);
        end
        rst_n = 1'b1; ovf_clr = 1'b0;
        tick();
        n_checks++;
        if (pending !== 8'hFF || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_capture: got pending %h valid %b, required ff 0", pending, out_valid);
        end
        din = 8'h00;
        for (int i = 0; i < 8; i++) exp_q.push_back(i);
        wait_drain(60);
        n_checks++;
        if (pending !== 8'h00 || out_valid !== 1'b0 || ovf !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_drain: got pending %h valid %b ovf %h, required 00 0 00",
                     pending, out_valid, ovf);
        end
    endtask

    task automatic test_two_grants();
        out_ready = 1'b1;
        din = 8'b0010_0100;
        tick();
        din = 8'h00;
        exp_q.push_back(2);
        exp_q.push_back(5);
        wait_drain(20);
        n_checks++;
        if (last_grant_cyc - prev_grant_cyc != 2) begin
            n_fail++;
            $display("FAIL grant_spacing: got %0d cycles, required 2", last_grant_cyc - prev_grant_cyc);
        end
        n_checks++;
        if (pending !== 8'h00 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL two_grants_idle: got pending %h valid %b, required 00 0", pending, out_valid);
        end
    endtask

    task automatic test_wrap();
        out_ready = 1'b1;
        din = 8'b0000_0011;
        tick();
        din = 8'h00;
        exp_q.push_back(0);
        exp_q.push_back(1);
        wait_drain(20);
    endtask

    task automatic test_hold();
        out_ready = 1'b0;
        din = 8'h08;
        tick();
        din = 8'h00;
        exp_q.push_back(3);
        exp_q.push_back(1);
        wait_valid(10);
        din = 8'h02;
        for (int i = 0; i < 5; i++) begin
            tick();
            din = 8'h00;
            n_checks++;
            if (out_valid !== 1'b1 || out_idx !== 3'd3) begin
                n_fail++;
                $display("FAIL hold_stable: got valid %b idx %0d, required 1 3", out_valid, out_idx);
            end
        end
        out_ready = 1'b1;
        wait_drain(20);
    endtask

    task automatic test_ovf();
        out_ready = 1'b0;
        din = 8'h10;
        tick();
        din = 8'h00;
        tick();
        din = 8'h10;
        tick();
        n_checks++;
        if (ovf !== 8'h10) begin
            n_fail++;
            $display("FAIL ovf_set: got %h, required 10", ovf);
        end
        ovf_clr = 1'b1;
        din = 8'h10;
        tick();
        n_checks++;
        if (ovf !== 8'h10) begin
            n_fail++;
            $display("FAIL ovf_event_beats_clr: got %h, required 10", ovf);
        end
        din = 8'h00;
        tick();
        ovf_clr = 1'b0;
        n_checks++;
        if (ovf !== 8'h00) begin
            n_fail++;
            $display("FAIL ovf_clr: got %h, required 00", ovf);
        end
        out_ready = 1'b1;
        din = 8'h10;
        exp_q.push_back(4);
        exp_q.push_back(4);
        tick();
        din = 8'h00;
        n_checks++;
        if (pending !== 8'h10 || ovf !== 8'h00) begin
            n_fail++;
            $display("FAIL set_beats_clear: got pending %h ovf %h, required 10 00", pending, ovf);
        end
        wait_drain(20);
        n_checks++;
        if (pending !== 8'h00 || ovf !== 8'h00) begin
            n_fail++;
            $display("FAIL ovf_drain: got pending %h ovf %h, required 00 00", pending, ovf);
        end
    endtask

    task automatic test_reset_mid_offer();
        out_ready = 1'b0;
        din = 8'h42;
        tick();
        din = 8'h00;
        wait_valid(10);
        n_checks++;
        if (out_idx !== 3'd6) begin
            n_fail++;
            $display("FAIL mid_offer_idx: got %0d, required 6", out_idx);
        end
        rst_n = 1'b0; out_ready = 1'b1; din = 8'hFF;
        tick();
        n_checks++;
        if ({out_valid, pending, ovf, out_idx} !== {1'b0, 8'h00, 8'h00, 3'd0}) begin
            n_fail++;
            $display("FAIL mid_offer_reset: got valid %b pending %h ovf %h idx %0d, required 0 00 00 0",
                     out_valid, pending, ovf, out_idx);
        end
        rst_n = 1'b1;
        din = 8'h88;
        exp_q.push_back(3);
        exp_q.push_back(7);
        tick();
        din = 8'h00;
        wait_drain(20);
    endtask

    initial begin
        rst_n = 1'b0; din = 8'h00; out_ready = 1'b0; ovf_clr = 1'b0;
        test_reset();
        test_two_grants();
        test_wrap();
        test_hold();
        test_ovf();
        test_reset_mid_offer();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
